// File: rtl/fp_align_pkg.sv
// -----------------------------------------------------------------------------
// fp_align_pkg
//   Shared constants and types for the floating-point adder alignment stage.
//
//   Contents:
//     EXP_W_DEF / MAN_W_DEF  default exponent / stored-mantissa field widths
//     PAD_W                  pad bits appended below the mantissa (G, R, S)
//     ext_w()                aligned mantissa width for a given MAN_W
//     fp_unpacked_t          unpacked operand (sign, effective exponent, sig)
//     s1_payload_t           stage-1 register payload
//
//   Configuration macro: FPADD_ALIGN_GRS_EN
//     defined   -> EXT_W = MAN_W+4, guard/round/sticky bits below the mantissa
//     undefined -> EXT_W = MAN_W+1, shifted-out bits discarded
// -----------------------------------------------------------------------------
package fp_align_pkg;

  localparam int unsigned EXP_W_DEF = 8;
  localparam int unsigned MAN_W_DEF = 23;

`ifdef FPADD_ALIGN_GRS_EN
  localparam int unsigned PAD_W = 3;
`else
  localparam int unsigned PAD_W = 0;
`endif

  // Aligned mantissa width: hidden bit + stored mantissa + optional G/R/S.
  function automatic int unsigned ext_w(input int unsigned man_w);
    return man_w + 1 + PAD_W;
  endfunction

  // Reference layouts at the default widths. Packed structs cannot take
  // module parameters, so fp_align_pipe re-declares the same layouts sized
  // from its own EXP_W/MAN_W.
  typedef struct packed {
    logic                 sign;
    logic [EXP_W_DEF-1:0] eff_exp;
    logic [MAN_W_DEF:0]   sig;      // {hidden, man}
  } fp_unpacked_t;

  typedef struct packed {
    logic                 sign_big;
    logic                 sign_small;
    logic                 swap;
    logic [EXP_W_DEF-1:0] exp_big;
    logic [EXP_W_DEF-1:0] diff;
    logic [MAN_W_DEF:0]   sig_big;
    logic [MAN_W_DEF:0]   sig_small;
  } s1_payload_t;

endpackage

// File: rtl/fp_align_shifter.sv
// -----------------------------------------------------------------------------
// fp_align_shifter
//   Combinational right shifter with saturation and optional sticky merge.
//
//   Parameters:
//     EXT_W  data width
//     SH_W   shift-amount width
//   Ports:
//     i_val  in   EXT_W  value to shift
//     i_sh   in   SH_W   shift amount (unsigned)
//     o_val  out  EXT_W  i_val >> i_sh; zero when i_sh >= EXT_W
//
//   Configuration macro: FPADD_ALIGN_GRS_EN
//     defined   -> LSB of o_val is ORed with every bit shifted out below it
//     undefined -> shifted-out bits are simply dropped
// -----------------------------------------------------------------------------
module fp_align_shifter #(
  parameter int unsigned EXT_W = 24,
  parameter int unsigned SH_W  = 8
) (
  input  logic [EXT_W-1:0] i_val,
  input  logic [SH_W-1:0]  i_sh,
  output logic [EXT_W-1:0] o_val
);

  logic             w_sat;
  logic [EXT_W-1:0] w_shifted;

  assign w_sat     = (32'(i_sh) >= EXT_W);
  assign w_shifted = w_sat ? '0 : (i_val >> i_sh);

`ifdef FPADD_ALIGN_GRS_EN
  logic [EXT_W-1:0] w_lost_mask;
  logic             w_sticky;

  // Mask of the bit positions that fall off the bottom; saturated shifts
  // lose the whole word.
  assign w_lost_mask = w_sat ? '1 : ~({EXT_W{1'b1}} << i_sh);
  assign w_sticky    = |(i_val & w_lost_mask);
  assign o_val       = {w_shifted[EXT_W-1:1], w_shifted[0] | w_sticky};
`else
  assign o_val = w_shifted;
`endif

endmodule

// File: rtl/fp_align_pipe.sv
// -----------------------------------------------------------------------------
// fp_align_pipe
//   Two-stage valid/ready alignment stage for the floating-point adder.
//   Stage 1 unpacks both operands, picks the larger magnitude and computes the
//   exponent difference; stage 2 right-shifts the smaller significand.
//
//   Parameters:
//     EXP_W  exponent field width (default 8)
//     MAN_W  stored mantissa field width (default 23); operand = 1+EXP_W+MAN_W
//   Ports:
//     clk         in   1      rising-edge clock
//     reset       in   1      asynchronous active-high reset
//     in_valid    in   1      operand pair valid
//     in_ready    out  1      pair accepted this cycle (comb. from out_ready)
//     a, b        in   W      raw operands
//     out_valid   out  1      aligned result valid
//     out_ready   in   1      downstream accepts the result
//     sign_big    out  1      sign of larger-magnitude operand
//     sign_small  out  1      sign of smaller-magnitude operand
//     eff_sub     out  1      sign_big ^ sign_small
//     swap        out  1      b was selected as the larger operand
//     exp_out     out  EXP_W  effective exponent of the larger operand
//     man_big     out  EXT_W  {hidden, man[, 000]}
//     man_small   out  EXT_W  {hidden, man[, 000]} >> diff (with sticky)
//
//   Configuration macro: FPADD_ALIGN_GRS_EN (see fp_align_pkg).
// -----------------------------------------------------------------------------
module fp_align_pipe
  import fp_align_pkg::*;
#(
  parameter int unsigned EXP_W = EXP_W_DEF,
  parameter int unsigned MAN_W = MAN_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+MAN_W:0]    a,
  input  logic [EXP_W+MAN_W:0]    b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sign_big,
  output logic                    sign_small,
  output logic                    eff_sub,
  output logic                    swap,
  output logic [EXP_W-1:0]        exp_out,
  output logic [ext_w(MAN_W)-1:0] man_big,
  output logic [ext_w(MAN_W)-1:0] man_small
);

  localparam int unsigned W     = 1 + EXP_W + MAN_W;
  localparam int unsigned EXT_W = ext_w(MAN_W);

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] eff_exp;
    logic [MAN_W:0]   sig;
  } unp_t;

  typedef struct packed {
    logic             sign_big;
    logic             sign_small;
    logic             swap;
    logic [EXP_W-1:0] exp_big;
    logic [EXP_W-1:0] diff;
    logic [MAN_W:0]   sig_big;
    logic [MAN_W:0]   sig_small;
  } s1_t;

  // Denormals and zero: effective exponent 1, hidden bit 0.
  function automatic unp_t unpack(input logic [W-1:0] x);
    unp_t             u;
    logic [EXP_W-1:0] e;
    e         = x[W-2 -: EXP_W];
    u.sign    = x[W-1];
    u.eff_exp = (e == '0) ? EXP_W'(1) : e;
    u.sig     = {(e != '0), x[MAN_W-1:0]};
    return u;
  endfunction

  // ---------------------------------------------------------------- stage 1
  unp_t w_ua, w_ub, w_big, w_small;
  logic w_b_gt_a;
  s1_t  w_s1_d;

  always_comb begin
    w_ua     = unpack(a);
    w_ub     = unpack(b);
    // Magnitude compare on {exp, man}; ties keep a as the big operand.
    w_b_gt_a = (b[W-2:0] > a[W-2:0]);
    w_big    = w_b_gt_a ? w_ub : w_ua;
    w_small  = w_b_gt_a ? w_ua : w_ub;

    w_s1_d            = '0;
    w_s1_d.sign_big   = w_big.sign;
    w_s1_d.sign_small = w_small.sign;
    w_s1_d.swap       = w_b_gt_a;
    w_s1_d.exp_big    = w_big.eff_exp;
    w_s1_d.diff       = w_big.eff_exp - w_small.eff_exp;
    w_s1_d.sig_big    = w_big.sig;
    w_s1_d.sig_small  = w_small.sig;
  end

  logic r_s1_valid;
  s1_t  r_s1;
  logic r_s2_valid;
  logic w_s2_load;

  assign w_s2_load = !r_s2_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s2_load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) r_s1 <= w_s1_d;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [EXT_W-1:0] w_sh_in;
  logic [EXT_W-1:0] w_big_ext;
  logic [EXT_W-1:0] w_sh_out;

`ifdef FPADD_ALIGN_GRS_EN
  assign w_sh_in   = {r_s1.sig_small, {PAD_W{1'b0}}};
  assign w_big_ext = {r_s1.sig_big,   {PAD_W{1'b0}}};
`else
  assign w_sh_in   = r_s1.sig_small;
  assign w_big_ext = r_s1.sig_big;
`endif

  fp_align_shifter #(
    .EXT_W (EXT_W),
    .SH_W  (EXP_W)
  ) u_shifter (
    .i_val (w_sh_in),
    .i_sh  (r_s1.diff),
    .o_val (w_sh_out)
  );

  logic             r_sign_big;
  logic             r_sign_small;
  logic             r_swap;
  logic [EXP_W-1:0] r_exp;
  logic [EXT_W-1:0] r_man_big;
  logic [EXT_W-1:0] r_man_small;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_valid   <= 1'b0;
      r_sign_big   <= 1'b0;
      r_sign_small <= 1'b0;
      r_swap       <= 1'b0;
      r_exp        <= '0;
      r_man_big    <= '0;
      r_man_small  <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sign_big   <= r_s1.sign_big;
        r_sign_small <= r_s1.sign_small;
        r_swap       <= r_s1.swap;
        r_exp        <= r_s1.exp_big;
        r_man_big    <= w_big_ext;
        r_man_small  <= w_sh_out;
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign sign_big   = r_sign_big;
  assign sign_small = r_sign_small;
  assign eff_sub    = r_sign_big ^ r_sign_small;
  assign swap       = r_swap;
  assign exp_out    = r_exp;
  assign man_big    = r_man_big;
  assign man_small  = r_man_small;

endmodule
